// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer: FSM state encoding and shift modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/result bundle between a command source (master) and the shift sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: none; the master watches busy and must not expect starts during busy to be queued.
// Signals: start/data_in/amt/mode (command), busy/done/result (status and result).
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amt;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, data_in, amt, mode,
    input  busy, done, result
  );

  modport slave (
    input  start, data_in, amt, mode,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer_shift1_unit.sv
// Combinational single-position shifter: LSR, ASR, LSL, and mode 11 (rotate right when
// SHIFT_SEQ_ROTATE_EN is defined, otherwise identical to LSR).
// Latency: 0 cycles. Backpressure: none.
// Ports: din (operand), mode (shift kind), dout (operand moved by one bit position).
module shift1_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = {1'b0, din[WIDTH-1:1]};
    case (mode)
      MODE_LSR: dout = {1'b0, din[WIDTH-1:1]};
      MODE_ASR: dout = {din[WIDTH-1], din[WIDTH-1:1]};
      MODE_LSL: dout = {din[WIDTH-2:0], 1'b0};
`ifdef SHIFT_SEQ_ROTATE_EN
      MODE_ROR: dout = {din[0], din[WIDTH-1:1]};
`else
      MODE_ROR: dout = {1'b0, din[WIDTH-1:1]};
`endif
      default:  dout = {1'b0, din[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a 1-bit shift unit amt times to realise an N-bit shift; done pulses one cycle
// with the result. Latency: done is high in the cycle after accept edge + amt.
// Backpressure: start is only sampled in IDLE; starts while busy/done are dropped, not queued.
// Ports: clk, rst (sync active-high), bus (slave side of shift_sequencer_if).
// Optional build macro: SHIFT_SEQ_ROTATE_EN (mode 11 rotates right instead of acting as LSR).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic clk,
  input  logic rst,
  shift_sequencer_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] count;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] shifted;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  shift1_unit #(.WIDTH(WIDTH)) u_shift1 (
    .din  (work),
    .mode (mode_q),
    .dout (shifted)
  );

  // Outputs are registered alongside the state so that busy/done/result change
  // exactly on the edges that move the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      count    <= '0;
      mode_q   <= MODE_LSR;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= bus.data_in;
            count  <= bus.amt;
            mode_q <= bus.mode;
            busy_q <= 1'b1;
            if (bus.amt == '0) begin
              // Zero-step command: the operand itself is the result.
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= bus.data_in;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count - 1'b1;
          // Last step: capture the value the work register is taking on this edge.
          if (count == AMT_W'(1)) begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= shifted;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
